// File: rtl/pwm_capture.sv
// Measures pulse width and centre phase of one selected PWM line over each 512-cycle period.
// Optional glitch counter on ERR_CNT is built when PWM_CAPTURE_ERR_CNT_EN is defined.
module pwm_capture #(
    parameter int unsigned DEPTH = 249
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [8:0]       TIME_CNT,
    input  logic [DEPTH-1:0] PWM_IN,
    input  logic [7:0]       SEL,
    output logic [9:0]       PULSE_WIDTH,
    output logic [7:0]       PHASE,
    output logic             DOUT_VALID,
    output logic             GLITCH,
    output logic [7:0]       ERR_CNT
);

    localparam logic [7:0] SEL_OFF = 8'hFF;
    localparam logic [8:0] T_LAST  = 9'd511;
    localparam logic [8:0] T_FIRST = 9'd0;

    typedef enum logic [1:0] {IDLE, ARM, MEASURE, REPORT} state_t;

    state_t     state_q, state_d;
    logic       s_q, s_prev;
    logic [8:0] t_q;
    logic [7:0] sel_q;
    logic [1:0] n_rise, n_fall;
    logic [8:0] t_rise, t_fall;
    logic       lvl0;

    logic       line_c, rise_c, fall_c, track_c, sel_chg_c;
    logic [8:0] width_c, centre_c;
    logic [7:0] phase_c;
    logic       valid_c, glitch_c;
    logic [9:0] pw_c;
    logic [7:0] ph_c;

    assign line_c    = (32'(SEL) < DEPTH) ? PWM_IN[SEL] : 1'b0;
    assign rise_c    = s_q & ~s_prev;
    assign fall_c    = ~s_q & s_prev;
    assign track_c   = (state_q == MEASURE) || (state_q == REPORT);
    assign sel_chg_c = (SEL != sel_q);
    assign width_c   = t_fall - t_rise;
    assign centre_c  = t_rise + (width_c >> 1);
    assign phase_c   = 8'(centre_c >> 1);

    // Sample stage and per-window edge bookkeeping; sample t==0 restarts the window.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            s_q    <= 1'b0;
            s_prev <= 1'b0;
            t_q    <= '0;
            sel_q  <= SEL_OFF;
            n_rise <= '0;
            n_fall <= '0;
            t_rise <= '0;
            t_fall <= '0;
            lvl0   <= 1'b0;
        end else begin
            s_q    <= line_c;
            s_prev <= s_q;
            t_q    <= TIME_CNT;
            sel_q  <= SEL;
            if (track_c) begin
                if (t_q == T_FIRST) begin
                    n_rise <= {1'b0, rise_c};
                    n_fall <= {1'b0, fall_c};
                    lvl0   <= s_q;
                end else begin
                    if (rise_c && n_rise != 2'd3) n_rise <= n_rise + 2'd1;
                    if (fall_c && n_fall != 2'd3) n_fall <= n_fall + 2'd1;
                end
                if (rise_c) t_rise <= t_q;
                if (fall_c) t_fall <= t_q;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and REPORT evaluation; a SEL change overrides everything.
    always_comb begin
        state_d  = state_q;
        valid_c  = 1'b0;
        glitch_c = 1'b0;
        pw_c     = PULSE_WIDTH;
        ph_c     = PHASE;
        case (state_q)
            IDLE:    if (SEL != SEL_OFF) state_d = ARM;
            ARM:     if (t_q == T_LAST)  state_d = MEASURE;
            MEASURE: if (t_q == T_LAST)  state_d = REPORT;
            REPORT: begin
                state_d = MEASURE;
                if (n_rise == 2'd1 && n_fall == 2'd1) begin
                    valid_c = 1'b1;
                    pw_c    = {1'b0, width_c};
                    ph_c    = phase_c;
                end else if (n_rise == 2'd0 && n_fall == 2'd0) begin
                    valid_c = 1'b1;
                    pw_c    = lvl0 ? 10'd512 : 10'd0;
                    ph_c    = 8'd0;
                end else begin
                    glitch_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (sel_chg_c) begin
            state_d  = (SEL == SEL_OFF) ? IDLE : ARM;
            valid_c  = 1'b0;
            glitch_c = 1'b0;
            pw_c     = PULSE_WIDTH;
            ph_c     = PHASE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            PULSE_WIDTH <= '0;
            PHASE       <= '0;
            DOUT_VALID  <= 1'b0;
            GLITCH      <= 1'b0;
        end else begin
            DOUT_VALID <= valid_c;
            GLITCH     <= glitch_c;
            if (valid_c) begin
                PULSE_WIDTH <= pw_c;
                PHASE       <= ph_c;
            end
        end
    end

`ifdef PWM_CAPTURE_ERR_CNT_EN
    logic [7:0] err_q;

    // Saturating count of rejected periods, in step with the GLITCH strobe.
    always_ff @(posedge CLK) begin
        if (!RST_N)                          err_q <= '0;
        else if (glitch_c && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end

    assign ERR_CNT = err_q;
`else
    assign ERR_CNT = '0;
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// Directed scoreboard bench for pwm_capture: stimulus pushes expected results, a monitor pops on strobes.
module tb_pwm_capture;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic [8:0]   TIME_CNT;
    logic [248:0] PWM_IN;
    logic [7:0]   SEL;
    logic [9:0]   PULSE_WIDTH;
    logic [7:0]   PHASE;
    logic         DOUT_VALID;
    logic         GLITCH;
    logic [7:0]   ERR_CNT;

    pwm_capture #(.DEPTH(249)) dut (
        .CLK(CLK), .RST_N(RST_N), .TIME_CNT(TIME_CNT), .PWM_IN(PWM_IN), .SEL(SEL),
        .PULSE_WIDTH(PULSE_WIDTH), .PHASE(PHASE), .DOUT_VALID(DOUT_VALID),
        .GLITCH(GLITCH), .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int g;
        int pw;
        int ph;
        int err;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_tot  = 0;
    bit   zero_chk = 1'b0;
    bit   done = 1'b0;
    bit   first = 1'b1;
    int   exp_err = 0;

    // Pattern slots: 0 -> line 5, 1 -> line 7, 2 -> line 248; high on [lo0,hi0) or [lo1,hi1).
    int lo0[3], hi0[3], lo1[3], hi1[3];

    function automatic logic in_pat(input int k, input int t);
        return ((t >= lo0[k]) && (t < hi0[k])) || ((t >= lo1[k]) && (t < hi1[k]));
    endfunction

    task automatic set_pat(input int k, input int a, input int b, input int c, input int d);
        lo0[k] = a; hi0[k] = b; lo1[k] = c; hi1[k] = d;
    endtask

    task automatic push(input int g, input int pw, input int ph);
        exp_t e;
        e.g = g; e.pw = pw; e.ph = ph; e.err = exp_err;
        q.push_back(e);
    endtask

    task automatic run_period(input int sel_at, input logic [7:0] nsel, input int rst_at);
        for (int t = 0; t < 512; t++) begin
            @(posedge CLK);
            #1;
            RST_N    = (t != rst_at);
            zero_chk = (t == rst_at + 1) || (first && t == 0);
            if (t == sel_at) SEL = nsel;
            TIME_CNT = 9'(t);
            PWM_IN   = '0;
            PWM_IN[5]   = in_pat(0, t);
            PWM_IN[7]   = in_pat(1, t);
            PWM_IN[248] = in_pat(2, t);
        end
        first = 1'b0;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    initial begin
        RST_N = 1'b0; SEL = 8'hFF; TIME_CNT = '0; PWM_IN = '0;
        for (int k = 0; k < 3; k++) set_pat(k, 0, 0, 0, 0);
        repeat (3) @(posedge CLK);

        set_pat(0, 78, 178, 0, 0);
        set_pat(1, 462, 512, 0, 50);
        set_pat(2, 0, 256, 0, 0);
        run_period(0, 8'd5, -5);               // P0: arming
        run_period(-1, 8'd0, -5); push(0, 100, 64);
        run_period(-1, 8'd0, -5); push(0, 100, 64);
        set_pat(0, 10, 20, 30, 40);
        run_period(-1, 8'd0, -5);
`ifdef PWM_CAPTURE_ERR_CNT_EN
        exp_err = exp_err + 1;
`endif
        push(1, 100, 64);                      // glitch: outputs hold
        set_pat(0, 0, 0, 0, 0);
        run_period(-1, 8'd0, -5); push(0, 0, 0);
        run_period(300, 8'd7, -5);             // P5: aborted by SEL change
        run_period(-1, 8'd0, -5); push(0, 100, 0);
        set_pat(1, 0, 512, 0, 0);
        run_period(-1, 8'd0, -5); push(0, 512, 0);
        run_period(10, 8'hFF, -5);             // P8/P9: idle
        run_period(-1, 8'd0, -5);
        run_period(0, 8'd248, -5);             // P10: arming on line 248
        run_period(-1, 8'd0, -5); push(0, 256, 64);
        run_period(-1, 8'd0, -5); push(0, 256, 64);
        run_period(-1, 8'd0, 100);             // P13: reset mid-window
        exp_err = 0;
        run_period(-1, 8'd0, -5); push(0, 256, 64);
        run_period(-1, 8'd0, -5);
        done = 1'b1;
    end

    initial begin
        int   cyc = 0;
        exp_t e;
        forever begin
            @(negedge CLK);
            cyc++;
            if (cyc > 20000) begin
                n_tot++;
                $display("FAIL timeout: got %0d cycles expected at most 20000", cyc);
                $display("%0d/%0d checks passed", n_pass, n_tot);
                $finish;
            end
            if (zero_chk) begin
                chk("reset_pulse_width", int'(PULSE_WIDTH), 0);
                chk("reset_phase", int'(PHASE), 0);
                chk("reset_dout_valid", int'(DOUT_VALID), 0);
                chk("reset_glitch", int'(GLITCH), 0);
                chk("reset_err_cnt", int'(ERR_CNT), 0);
            end
            if (DOUT_VALID || GLITCH) begin
                if (q.size() == 0) begin
                    n_tot++;
                    $display("FAIL unexpected_strobe: got valid=%0d glitch=%0d expected none",
                             int'(DOUT_VALID), int'(GLITCH));
                end else begin
                    e = q.pop_front();
                    chk("glitch_flag", int'(GLITCH), e.g);
                    chk("valid_flag", int'(DOUT_VALID), 1 - e.g);
                    chk("pulse_width", int'(PULSE_WIDTH), e.pw);
                    chk("phase", int'(PHASE), e.ph);
                    chk("latency_time_cnt", int'(TIME_CNT), 2);
                    chk("err_cnt", int'(ERR_CNT), e.err);
                end
            end
            if (done) begin
                chk("queue_empty", q.size(), 0);
                $display("%0d/%0d checks passed", n_pass, n_tot);
                $finish;
            end
        end
    end

endmodule
